// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches over a valid/ready handshake and loads IF/ID.
// A one-entry skid buffer keeps a fetched word that arrives while decode is stalled.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic [31:0] next_pc,
  input  logic        wpcir,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic [31:0] dinst,
  output logic [31:0] dpc4,
  output logic        dvalid
);

  typedef enum logic [0:0] {StFetch, StHold} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] dinst_q;
  logic [31:0] dpc4_q;
  logic        dvalid_q;
  logic [31:0] buf_inst_q;
  logic [31:0] buf_pc4_q;

  assign pc        = pc_q;
  assign pc4       = pc_q + 32'd4;
  assign imem_addr = pc_q;
  assign imem_req  = (state_q == StFetch);
  assign dinst     = dinst_q;
  assign dpc4      = dpc4_q;
  assign dvalid    = dvalid_q;

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_q    <= StFetch;
      pc_q       <= RESET_PC;
      dinst_q    <= NOP_INST;
      dpc4_q     <= 32'd0;
      dvalid_q   <= 1'b0;
      buf_inst_q <= NOP_INST;
      buf_pc4_q  <= 32'd0;
    end else begin
      unique case (state_q)
        StFetch: begin
          if (flush) begin
            // Flush wins over a stall; any word returned this cycle is dropped.
            pc_q     <= next_pc;
            dinst_q  <= NOP_INST;
            dpc4_q   <= pc4;
            dvalid_q <= 1'b0;
          end else if (imem_ready && wpcir) begin
            pc_q     <= next_pc;
            dinst_q  <= imem_rdata;
            dpc4_q   <= pc4;
            dvalid_q <= 1'b1;
          end else if (imem_ready) begin
            buf_inst_q <= imem_rdata;
            buf_pc4_q  <= pc4;
            state_q    <= StHold;
          end else if (wpcir) begin
            dinst_q  <= NOP_INST;
            dvalid_q <= 1'b0;
          end
        end
        StHold: begin
          if (flush) begin
            pc_q     <= next_pc;
            dinst_q  <= NOP_INST;
            dpc4_q   <= pc4;
            dvalid_q <= 1'b0;
            state_q  <= StFetch;
          end else if (wpcir) begin
            pc_q     <= next_pc;
            dinst_q  <= buf_inst_q;
            dpc4_q   <= buf_pc4_q;
            dvalid_q <= 1'b1;
            state_q  <= StFetch;
          end
        end
        default: state_q <= StFetch;
      endcase
    end
  end

endmodule
